// File: rtl/mam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mam_pkg : encodings shared by the MAM initiator and the SRAM responder
// Revision: 1.0
// ---------------------------------------------------------------------------
package mam_pkg;

  localparam logic MAM_RW_READ  = 1'b0;
  localparam logic MAM_RW_WRITE = 1'b1;

  localparam int MAM_BEATS_WIDTH = 14;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_RD_FETCH = 2'd2,
    ST_RD_HOLD  = 2'd3
  } mam_resp_state_e;

endpackage
`default_nettype wire

// File: rtl/mam_sram_responder_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mam_sram_responder_mem : single-port sync RAM, byte write enables,
//                          one-cycle registered read
// Revision: 1.0
// ---------------------------------------------------------------------------
module mam_sram_responder_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 1024,
  parameter int IDXW       = $clog2(MEM_WORDS)
) (
  input  logic                    clk,
  input  logic [IDXW-1:0]         addr_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mam_sram_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mam_sram_responder : serves MAM single/burst requests from a local SRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module mam_sram_responder
  import mam_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_rw,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic                       req_burst,
  input  logic [MAM_BEATS_WIDTH-1:0] req_beats,
  input  logic                       write_valid,
  output logic                       write_ready,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic [DATA_WIDTH/8-1:0]    write_strb,
  output logic                       read_valid,
  input  logic                       read_ready,
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic                       busy,
  output logic                       err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * BYTES);
  localparam logic [IDXW-1:0]       LAST_IDX  = IDXW'(MEM_WORDS - 1);

  mam_resp_state_e             state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [MAM_BEATS_WIDTH-1:0]  count_q, count_d;
  logic                        range_q, range_d;
  logic                        err_q, err_d;

  logic [ADDR_WIDTH-1:0]       off;
  logic [MAM_BEATS_WIDTH-1:0]  req_count;
  logic [BYTES-1:0]            mem_we;
  logic                        mem_re;
  logic [DATA_WIDTH-1:0]       mem_rdata;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets.
  assign off       = req_addr - BASE_ADDR;
  assign req_count = (req_burst && (req_beats != '0)) ? req_beats : MAM_BEATS_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    range_d = range_q;
    err_d   = 1'b0;
    mem_we  = '0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          idx_d   = off[OFFW +: IDXW];
          range_d = (off < MEM_BYTES);
          count_d = req_count;
          state_d = (req_rw == MAM_RW_WRITE) ? ST_WRITE : ST_RD_FETCH;
        end
      end
      ST_WRITE: begin
        if (write_valid) begin
          mem_we  = range_q ? write_strb : '0;
          err_d   = ~range_q;
          idx_d   = idx_q + IDXW'(1);
          count_d = count_q - MAM_BEATS_WIDTH'(1);
          // Passing the top word leaves the rest of the burst out of range.
          range_d = range_q && (idx_q != LAST_IDX);
          if (count_q == MAM_BEATS_WIDTH'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD_FETCH: begin
        mem_re  = 1'b1;
        err_d   = ~range_q;
        state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (read_ready) begin
          idx_d   = idx_q + IDXW'(1);
          count_d = count_q - MAM_BEATS_WIDTH'(1);
          range_d = range_q && (idx_q != LAST_IDX);
          state_d = (count_q == MAM_BEATS_WIDTH'(1)) ? ST_IDLE : ST_RD_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      range_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      range_q <= range_d;
      err_q   <= err_d;
    end
  end

  mam_sram_responder_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDXW       (IDXW)
  ) u_mem (
    .clk     (clk),
    .addr_i  (idx_q),
    .we_i    (mem_we),
    .wdata_i (write_data),
    .re_i    (mem_re),
    .rdata_o (mem_rdata)
  );

  // The RAM output register only reloads in RD_FETCH, so it is stable while holding.
  assign read_data   = ((state_q == ST_RD_HOLD) && range_q) ? mem_rdata : '0;
  assign req_ready   = (state_q == ST_IDLE);
  assign write_ready = (state_q == ST_WRITE);
  assign read_valid  = (state_q == ST_RD_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mam_sram_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mam_sram_responder : directed + random checks against a word-array model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mam_sram_responder;

  localparam int          DW    = 64;
  localparam int          AW    = 64;
  localparam int          WORDS = 256;
  localparam logic [63:0] BASE  = 64'h1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_rw, req_burst;
  logic [63:0]   req_addr;
  logic [13:0]   req_beats;
  logic          write_valid, write_ready;
  logic [63:0]   write_data;
  logic [7:0]    write_strb;
  logic          read_valid, read_ready;
  logic [63:0]   read_data;
  logic          busy, err;

  int          tests = 0;
  int          fails = 0;
  int          err_cnt = 0;
  int          err_exp = 0;
  logic [63:0] model [WORDS];

  always #5 clk = ~clk;

  mam_sram_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_WORDS  (WORDS),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_burst   (req_burst),
    .req_beats   (req_beats),
    .write_valid (write_valid),
    .write_ready (write_ready),
    .write_data  (write_data),
    .write_strb  (write_strb),
    .read_valid  (read_valid),
    .read_ready  (read_ready),
    .read_data   (read_data),
    .busy        (busy),
    .err         (err)
  );

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Beat b of a request at addr is in range iff start word offset + b < WORDS.
  function automatic bit beat_inr(input logic [63:0] addr, input int b);
    logic [63:0] wo;
    wo = (addr - BASE) >> 3;
    return (wo + 64'(b)) < 64'(WORDS);
  endfunction

  function automatic int beat_idx(input logic [63:0] addr, input int b);
    return int'(((addr - BASE) >> 3) + 64'(b));
  endfunction

  function automatic int n_beats(input bit burst, input logic [13:0] beats);
    return (burst && beats != 0) ? int'(beats) : 1;
  endfunction

  // Called at a negedge; returns at the negedge following the handshake.
  task automatic send_req(input bit rw, input logic [63:0] addr, input bit burst,
                          input logic [13:0] beats);
    int w;
    req_valid = 1'b1; req_rw = rw; req_addr = addr;
    req_burst = burst; req_beats = beats;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    chk("busy_after_req", busy, 1);
  endtask

  // mode 0: random data, strb s0; mode 1: data d0+i, strb s0; mode 2: random data and strb
  task automatic do_write(input logic [63:0] addr, input bit burst, input logic [13:0] beats,
                          input int mode, input logic [63:0] d0, input logic [7:0] s0);
    int n;
    logic [63:0] d;
    logic [7:0]  s;
    n = n_beats(burst, beats);
    send_req(1'b1, addr, burst, beats);
    for (int i = 0; i < n; i++) begin
      d = (mode == 1) ? d0 + 64'(i) : {$urandom, $urandom};
      s = (mode == 2) ? 8'($urandom) : s0;
      write_valid = 1'b1; write_data = d; write_strb = s;
      chk("write_ready", write_ready, 1);
      if (beat_inr(addr, i)) begin
        for (int k = 0; k < 8; k++)
          if (s[k]) model[beat_idx(addr, i)][k*8 +: 8] = d[k*8 +: 8];
      end else begin
        err_exp++;
      end
      @(negedge clk);
    end
    write_valid = 1'b0;
    chk("wr_b2b_req_ready", req_ready, 1);
    @(negedge clk); #1;
    chk("wr_err_count", 64'(err_cnt), 64'(err_exp));
  endtask

  task automatic do_read(input logic [63:0] addr, input bit burst, input logic [13:0] beats,
                         input int hold_beat, input int hold_cyc);
    int n, w;
    logic [63:0] exp;
    n = n_beats(burst, beats);
    send_req(1'b0, addr, burst, beats);
    chk("rd_fetch_valid_low", read_valid, 0);
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (read_valid !== 1'b1 && w < 8) begin @(negedge clk); w++; end
      chk("rd_latency", 64'(w), 64'd1);
      exp = beat_inr(addr, i) ? model[beat_idx(addr, i)] : 64'd0;
      if (!beat_inr(addr, i)) err_exp++;
      chk("rd_data", read_data, exp);
      chk("rd_err_pulse", err, !beat_inr(addr, i));
      if (i == hold_beat) begin
        for (int c = 0; c < hold_cyc; c++) begin
          @(negedge clk);
          chk("bp_valid", read_valid, 1);
          chk("bp_data", read_data, exp);
          chk("bp_err_low", err, 0);
        end
      end
      read_ready = 1'b1;
      @(negedge clk);
      read_ready = 1'b0;
    end
    chk("rd_b2b_req_ready", req_ready, 1);
    @(negedge clk); #1;
    chk("rd_err_count", 64'(err_cnt), 64'(err_exp));
  endtask

  initial begin
    logic [63:0] a;
    rst = 1'b1;
    req_valid = 0; req_rw = 0; req_addr = 0; req_burst = 0; req_beats = 0;
    write_valid = 0; write_data = 0; write_strb = 0; read_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_write_ready", write_ready, 0);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fill the whole SRAM so every later read has a known expectation.
    do_write(BASE, 1'b1, 14'(WORDS), 0, 64'd0, 8'hFF);

    do_write(BASE + 64'h40, 1'b0, 14'd0, 1, 64'h1122334455667788, 8'hFF);
    do_read(BASE + 64'h40, 1'b0, 14'd0, -1, 0);
    chk("single_rd_const", model[8], 64'h1122334455667788);

    do_write(BASE, 1'b1, 14'd4, 1, 64'd0, 8'hFF);
    do_read(BASE, 1'b1, 14'd4, -1, 0);

    do_write(BASE + 64'h80, 1'b0, 14'd5, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(BASE + 64'h80, 1'b0, 14'd0, 1, 64'd0, 8'h0F);
    do_read(BASE + 64'h80, 1'b0, 14'd0, -1, 0);
    chk("strb_model_const", model[16], 64'hFFFF_FFFF_0000_0000);

    do_write(BASE + 64'(254 * 8), 1'b1, 14'd3, 0, 64'd0, 8'hFF);
    do_read(BASE + 64'(255 * 8), 1'b1, 14'd3, -1, 0);
    do_read(BASE - 64'd8, 1'b0, 14'd0, -1, 0);
    do_write(BASE - 64'd8, 1'b0, 14'd0, 0, 64'd0, 8'hFF);

    do_read(BASE + 64'h100, 1'b1, 14'd6, 2, 5);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE - 64'(8 * $urandom_range(1, 4));
        1:       a = BASE + 64'(8 * $urandom_range(WORDS - 4, WORDS - 1));
        default: a = BASE + 64'(8 * $urandom_range(0, WORDS - 1));
      endcase
      a = a + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        do_write(a, 1'($urandom), 14'($urandom_range(0, 6)), 2, 64'd0, 8'h00);
      else
        do_read(a, 1'($urandom), 14'($urandom_range(0, 6)), -1, 0);
    end

    // Reset during the second beat of an 8-beat write.
    send_req(1'b1, BASE + 64'h200, 1'b1, 14'd8);
    a = {$urandom, $urandom};
    write_valid = 1'b1; write_data = a; write_strb = 8'hFF;
    model[64] = a;
    @(negedge clk);
    write_data = ~a;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_write_ready", write_ready, 0);
    chk("mid_rst_read_valid", read_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    write_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);
    do_read(BASE + 64'h200, 1'b1, 14'd8, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
